// File: rtl/su_mac_pkg.sv
// Shared types and helpers for the signed x unsigned MAC accumulate path.
// Saturation bounds are used only when SU_ACC_SAT_EN is defined.
package su_mac_pkg;

    localparam int PROD_W = 8;

    typedef enum logic {ST_ACC, ST_OUT} su_acc_state_t;

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/su_sat_add.sv
// Adds a sign-extended 8-bit product to an ACC_W accumulator.
// SU_ACC_SAT_EN selects a clamping add with a sat flag; otherwise the add wraps and sat is 0.
module su_sat_add
    import su_mac_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic        [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     sat
);

    logic signed [ACC_W-1:0] prod_ext;

    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef SU_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] wide;

    // One guard bit: overflow shows as the top two bits disagreeing.
    always_comb begin
        wide = {acc_in[ACC_W-1], acc_in} + {prod_ext[ACC_W-1], prod_ext};
        sum  = wide[ACC_W-1:0];
        sat  = 1'b0;
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sat = 1'b1;
            sum = wide[ACC_W] ? MIN_V : MAX_V;
        end
    end
`else
    assign sum = acc_in + prod_ext;
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/su_prod_accum.sv
// Accumulates signed 8-bit products into one ACC_W result per vector (valid/ready both sides).
// Build option SU_ACC_SAT_EN enables per-add saturation and the out_sat report.
//
//   state  | meaning
//   ST_ACC | taking beats, summing into acc_q; vector closes on in_last or MAX_TERMS
//   ST_OUT | result held on out_*, waiting for out_ready; input stalled
module su_prod_accum
    import su_mac_pkg::*;
#(
    parameter  int ACC_W     = 16,
    parameter  int MAX_TERMS = 256,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [PROD_W-1:0] in_prod,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic        [CNT_W-1:0] out_count,
    output logic                    out_sat
);

    su_acc_state_t           state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic                    sat_q, sat_d;
    logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
    logic        [CNT_W-1:0] out_count_q, out_count_d;
    logic                    out_sat_q, out_sat_d;

    logic signed [ACC_W-1:0] add_sum;
    logic                    add_sat;
    logic        [CNT_W-1:0] cnt_inc;
    logic                    take;

    su_sat_add #(.ACC_W(ACC_W)) u_add (
        .acc_in (acc_q),
        .prod   (in_prod),
        .sum    (add_sum),
        .sat    (add_sat)
    );

    assign in_ready  = (state_q == ST_ACC) & ~clr;
    assign out_valid = (state_q == ST_OUT);
    assign take      = in_valid & in_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            ST_ACC: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    sat_d = 1'b0;
                end else if (take) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    sat_d = sat_q | add_sat;
                    // Output registers load only here, so they keep showing the last result in ST_ACC.
                    if (in_last || (cnt_inc == CNT_W'(MAX_TERMS))) begin
                        out_acc_d   = add_sum;
                        out_count_d = cnt_inc;
                        out_sat_d   = sat_q | add_sat;
                        state_d     = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_su_prod_accum.sv
// Bench for su_prod_accum: a wide instance (16 bit, 256 terms) and a narrow one (9 bit, 4 terms)
// checked every cycle against a vector-level model, plus directed scenarios with literal results.
module tb_su_prod_accum;

    localparam int W0 = 16, M0 = 256;
    localparam int W1 = 9,  M1 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       iv[2], il[2], cl[2], ordy[2];
    logic [7:0] pr[2];

    logic        ir0, ir1, ov0, ov1, st0, st1;
    logic [15:0] acc0;
    logic [8:0]  acc1;
    logic [8:0]  cnt0;
    logic [2:0]  cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    su_prod_accum #(.ACC_W(W0), .MAX_TERMS(M0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(cl[0]),
        .in_valid(iv[0]), .in_ready(ir0), .in_prod(pr[0]), .in_last(il[0]),
        .out_valid(ov0), .out_ready(ordy[0]),
        .out_acc(acc0), .out_count(cnt0), .out_sat(st0)
    );

    su_prod_accum #(.ACC_W(W1), .MAX_TERMS(M1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(cl[1]),
        .in_valid(iv[1]), .in_ready(ir1), .in_prod(pr[1]), .in_last(il[1]),
        .out_valid(ov1), .out_ready(ordy[1]),
        .out_acc(acc1), .out_count(cnt1), .out_sat(st1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- vector-level reference model ----------------
    bit  pend[2];
    int  rs_acc[2], rs_cnt[2];
    bit  rs_sat[2];
    int  nt[2];
    int  terms[2][256];

    function automatic int wid(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    function automatic int maxt(input int k);
        return (k == 0) ? M0 : M1;
    endfunction

    task automatic close_vec(input int k);
        longint hi, lo, m, s;
        bit     sat;
        hi  = (longint'(1) << (wid(k) - 1)) - 1;
        lo  = -(longint'(1) << (wid(k) - 1));
        m   = longint'(1) << wid(k);
        s   = 0;
        sat = 1'b0;
        for (int i = 0; i < nt[k]; i++) begin
            s += terms[k][i];
`ifdef SU_ACC_SAT_EN
            if (s > hi) begin s = hi; sat = 1'b1; end
            if (s < lo) begin s = lo; sat = 1'b1; end
`endif
        end
`ifndef SU_ACC_SAT_EN
        s = s % m;
        if (s < 0) s += m;
        if (s > hi) s -= m;
`endif
        rs_acc[k] = int'(s);
        rs_cnt[k] = nt[k];
        rs_sat[k] = sat;
        pend[k]   = 1'b1;
    endtask

    task automatic model_step(input int k, input bit ov, input bit ir,
                              input int acc, input int cnt, input bit sat);
        if (!rst_n) begin
            pend[k] = 1'b0; nt[k] = 0;
            rs_acc[k] = 0; rs_cnt[k] = 0; rs_sat[k] = 1'b0;
            chk($sformatf("d%0d_rst_out_valid", k), int'(ov), 0);
            chk($sformatf("d%0d_rst_out_acc", k), acc, 0);
            chk($sformatf("d%0d_rst_out_count", k), cnt, 0);
            chk($sformatf("d%0d_rst_out_sat", k), int'(sat), 0);
            return;
        end
        chk($sformatf("d%0d_out_valid", k), int'(ov), int'(pend[k]));
        chk($sformatf("d%0d_in_ready", k), int'(ir), int'(!pend[k] && !cl[k]));
        chk($sformatf("d%0d_out_acc", k), acc, rs_acc[k]);
        chk($sformatf("d%0d_out_count", k), cnt, rs_cnt[k]);
        chk($sformatf("d%0d_out_sat", k), int'(sat), int'(rs_sat[k]));
        if (pend[k]) begin
            if (ordy[k]) begin
                pend[k] = 1'b0;
                nt[k]   = 0;
            end
        end else if (cl[k]) begin
            nt[k] = 0;
        end else if (iv[k]) begin
            terms[k][nt[k]] = $signed(pr[k]);
            nt[k]++;
            if (il[k] || nt[k] == maxt(k)) close_vec(k);
        end
    endtask

    always @(negedge clk) begin
        model_step(0, ov0, ir0, $signed(acc0), int'(cnt0), st0);
        model_step(1, ov1, ir1, $signed(acc1), int'(cnt1), st1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        iv[k] = 1'b0; il[k] = 1'b0; cl[k] = 1'b0; ordy[k] = 1'b1; pr[k] = 8'h00;
    endtask

    initial begin
        idle(0);
        idle(1);
        #1 rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Basic vector 105, -120, 7, then backpressure with a pending beat
        ordy[0] = 1'b0;
        iv[0] = 1'b1; pr[0] = 8'd105; il[0] = 1'b0;
        step();
        pr[0] = 8'h88;
        step();
        pr[0] = 8'd7; il[0] = 1'b1;
        step();
        pr[0] = 8'd9; il[0] = 1'b1;
        chk("basic_valid", int'(ov0), 1);
        chk("basic_acc", int'(acc0), 'hFFF8);
        chk("basic_count", int'(cnt0), 3);
        chk("basic_sat", int'(st0), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_acc_stable", int'(acc0), 'hFFF8);
            chk("bp_count_stable", int'(cnt0), 3);
            chk("bp_in_ready", int'(ir0), 0);
        end
        ordy[0] = 1'b1;
        step();
        chk("bp_release_valid", int'(ov0), 0);
        chk("bp_release_ready", int'(ir0), 1);
        step();
        chk("bp_pending_valid", int'(ov0), 1);
        chk("bp_pending_acc", int'(acc0), 9);
        chk("bp_pending_count", int'(cnt0), 1);
        iv[0] = 1'b0; il[0] = 1'b0;
        step();

        // Reset in the middle of a vector
        iv[0] = 1'b1; pr[0] = 8'd50; il[0] = 1'b0;
        step(); step();
        rst_n = 1'b0; iv[0] = 1'b0;
        #1;
        chk("rst_valid", int'(ov0), 0);
        chk("rst_acc", int'(acc0), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", int'(ir0), 1);
        iv[0] = 1'b1; pr[0] = 8'd4; il[0] = 1'b1;
        step();
        chk("rst_fresh_acc", int'(acc0), 4);
        chk("rst_fresh_count", int'(cnt0), 1);
        iv[0] = 1'b0; il[0] = 1'b0;
        step();

        // clr abandons a vector and blocks the beat presented with it
        iv[0] = 1'b1; pr[0] = 8'd10;
        step();
        pr[0] = 8'd20;
        step();
        pr[0] = 8'd3; cl[0] = 1'b1;
        #1;
        chk("clr_in_ready", int'(ir0), 0);
        step();
        cl[0] = 1'b0; pr[0] = 8'd5; il[0] = 1'b1;
        step();
        chk("clr_acc", int'(acc0), 5);
        chk("clr_count", int'(cnt0), 1);
        iv[0] = 1'b0; il[0] = 1'b0;
        step();

        // Narrow instance: width limit
        iv[1] = 1'b1; pr[1] = 8'd105; il[1] = 1'b0;
        step(); step();
        il[1] = 1'b1;
        step();
`ifdef SU_ACC_SAT_EN
        chk("w9_acc", int'(acc1), 255);
        chk("w9_sat", int'(st1), 1);
`else
        chk("w9_acc", int'(acc1), 'h13B);
        chk("w9_sat", int'(st1), 0);
`endif
        chk("w9_count", int'(cnt1), 3);
        iv[1] = 1'b0; il[1] = 1'b0;
        step();

        // Narrow instance: MAX_TERMS closes the vector
        iv[1] = 1'b1; pr[1] = 8'd1; il[1] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("max_valid", int'(ov1), 1);
        chk("max_acc", int'(acc1), 4);
        chk("max_count", int'(cnt1), 4);
        iv[1] = 1'b0;
        step();

        // Random traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                int t;
                t = $urandom_range(0, 225);
                pr[k]   = 8'(t - 120);
                iv[k]   = ($urandom_range(0, 3) != 0);
                il[k]   = ($urandom_range(0, 5) == 0);
                cl[k]   = ($urandom_range(0, 19) == 0);
                ordy[k] = ($urandom_range(0, 9) < 7);
            end
            step();
        end

        // Long vectors on the wide instance to reach MAX_TERMS
        idle(1);
        cl[0] = 1'b0; il[0] = 1'b0; ordy[0] = 1'b1; iv[0] = 1'b1;
        for (int c = 0; c < 600; c++) begin
            int t;
            t = $urandom_range(0, 225);
            pr[0] = 8'(t - 120);
            step();
        end
        idle(0);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
